synch_up_counter: RTL and testbench
===================================

// Module: synch_up_counter
// PURPOSE
//   Synchronous loadable modulo up counter: counts 0..limit and wraps (or stops),
//   with terminal-count, wrap and overflow status. Up-counting counterpart of the
//   synchronous down counter; same d/clk/rst/q port style, drives timers and sequencers.
// PARAMETERS
//   WIDTH     4   counter/data width in bits
//   ONE_SHOT  0   0 = wrap to 0 at terminal; 1 = stop at terminal and assert done
// PORTS
//   clk    in   1      rising-edge clock, single clock domain
//   rst    in   1      asynchronous, active-low reset (0 = reset)
//   d      in   WIDTH  parallel load value
//   load   in   1      synchronous load strobe; highest priority after reset
//   en     in   1      count enable
//   limit  in   WIDTH  terminal value; counter range is 0..limit
//   q      out  WIDTH  registered count
//   tc     out  1      terminal count: combinational (q >= limit)
//   wrap   out  1      registered 1-cycle pulse after a q -> 0 wrap
//   ovf    out  1      sticky flag, set by any wrap
//   done   out  1      registered; 1 while FSM is in DONE (ONE_SHOT=1 only)
//   busy   out  1      registered; 1 while FSM is in RUN
// BEHAVIOUR
//   Reset: rst=0 forces immediately, without waiting for clk: q=0, wrap=0, ovf=0,
//     done=0, busy=0, FSM=IDLE. Mid-count reset aborts with no pulse. Release is sync to next edge.
//   FSM: IDLE, RUN, DONE; priority per edge: load > terminal > en.
//     IDLE: q holds; en=1 -> RUN and q increments on that same edge.
//     RUN: per edge with en=1, q <= q+1 while q < limit; en=0 -> IDLE, q holds.
//     Terminal in RUN (en=1, q >= limit):
//       ONE_SHOT=0: q <= 0, wrap <= 1 for one cycle, ovf <= 1; stays in RUN.
//       ONE_SHOT=1: q holds, FSM -> DONE, no wrap, no ovf.
//     DONE: q, done held; en ignored; only load or reset exits.
//   load=1 (any state): q <= d, FSM -> IDLE, ovf <= 0, wrap <= 0, done <= 0.
//     load with en=1 on the same edge: load wins, no increment that cycle.
//   d > limit: q takes d as-is; tc=1 at once; next counting edge is terminal.
//   limit changed below q mid-count: next counting edge is terminal (>= compare).
//   limit=0: every counting edge is terminal (q stays 0; wrap pulses each edge).
//   Arithmetic: unsigned, WIDTH bits; q never exceeds max(limit, last d);
//     limit = all-ones wraps as plain 2^WIDTH rollover.
//   Latency: q, wrap, done, busy update on the edge that samples inputs; tc follows
//     q and limit combinationally within the same cycle.
// TESTING
//   1. d=0001,load 1 cyc,limit=1111,en=1 -> q=1111 after 14 edges, tc=1; next edge
//      q=0000, wrap=1 for exactly 1 cycle, ovf=1 and stays 1.
//   2. limit=0101, q=0, en=1 for 7 edges -> q 1,2,3,4,5,0,1; wrap once after 6th edge.
//   3. en=1 and load=1 same edge with d=0011, q=0111 -> q=0011 (not 0100); ovf cleared.
//   4. ONE_SHOT=1, limit=0011, en=1 -> q stops at 0011, done=1, busy=0; toggling en no
//      effect; load d=0000 -> q=0, done=0, FSM IDLE.
//   5. load d=1010, limit=0101 -> tc=1 immediately; next en edge q=0000, wrap=1.
//   6. rst=0 asserted mid-edge-window at q=0110, en=1 -> q=0, all flags 0 before next
//      clk edge; rst=1 with en=1 -> counting resumes from 0001 on first edge.

Source files
------------

// File: rtl/synch_up_counter.sv
// ----------------------------------------------------------------------------
// synch_up_counter
//
// Synchronous loadable modulo up counter. Counts 0..limit and then either
// wraps back to 0 (ONE_SHOT=0) or parks at the terminal value (ONE_SHOT=1).
// Reports terminal count, a one-cycle wrap pulse, a sticky overflow flag, and
// the run/done state of its small control FSM. Intended to drive timers and
// sequencers.
//
// Parameters
//   WIDTH     counter / data width in bits
//   ONE_SHOT  0 = wrap to 0 at terminal, 1 = stop at terminal and assert done
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-low reset (0 = reset)
//   d      in   WIDTH  parallel load value
//   load   in   1      synchronous load strobe, highest priority after reset
//   en     in   1      count enable
//   limit  in   WIDTH  terminal value, counting range is 0..limit
//   q      out  WIDTH  registered count
//   tc     out  1      terminal count, combinational (q >= limit)
//   wrap   out  1      registered 1-cycle pulse after a q -> 0 wrap
//   ovf    out  1      sticky flag, set by any wrap, cleared by load
//   done   out  1      registered, 1 while the FSM is in DONE
//   busy   out  1      registered, 1 while the FSM is in RUN
// ----------------------------------------------------------------------------
module synch_up_counter #(
    parameter int WIDTH    = 4,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;
    logic             at_term;

    // A ">=" compare (not "==") makes a loaded value above limit, or a limit
    // lowered underneath a running count, terminal on the very next count.
    assign at_term = (q >= limit);
    assign tc      = at_term;

    // ------------------------------------------------------------------------
    // Next-state / next-count logic. Priority per edge: load > terminal > en.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        q_nxt     = q;
        wrap_nxt  = 1'b0;
        ovf_nxt   = ovf;

        if (load) begin
            // Load wins over counting; the loaded value is taken as-is even
            // when it exceeds limit.
            q_nxt     = d;
            state_nxt = IDLE;
            ovf_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE, RUN: begin
                    if (en) begin
                        if (at_term) begin
                            if (ONE_SHOT) begin
                                // Park on the terminal value; no wrap, no ovf.
                                state_nxt = DONE;
                            end else begin
                                q_nxt     = '0;
                                wrap_nxt  = 1'b1;
                                ovf_nxt   = 1'b1;
                                state_nxt = RUN;
                            end
                        end else begin
                            // q < limit here, so q+1 can never roll over; an
                            // all-ones limit reaches 0 only via the wrap path.
                            q_nxt     = q + 1'b1;
                            state_nxt = RUN;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end

                DONE: begin
                    // Only load (above) or reset leaves DONE; en is ignored.
                    state_nxt = DONE;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. done/busy are registered from the next
    // state so they line up exactly with the state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state <= state_nxt;
            q     <= q_nxt;
            wrap  <= wrap_nxt;
            ovf   <= ovf_nxt;
            done  <= (state_nxt == DONE);
            busy  <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_synch_up_counter.sv
// ----------------------------------------------------------------------------
// tb_synch_up_counter
//
// Runs a wrapping (ONE_SHOT=0) and a one-shot (ONE_SHOT=1) instance side by
// side on shared stimulus. A behavioural model, written in terms of plain
// integers and run/stopped flags, predicts every output after every edge.
// Directed scenarios cover load/en priority, wrap, limit=0, d > limit,
// one-shot stop and asynchronous reset; randomized traffic follows.
// ----------------------------------------------------------------------------
module tb_synch_up_counter;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [W-1:0]        d = '0;
    logic [W-1:0]        limit = '0;
    logic                load = 1'b0;
    logic                en = 1'b0;

    logic [1:0][W-1:0]   q_o;
    logic [1:0]          tc_o;
    logic [1:0]          wrap_o;
    logic [1:0]          ovf_o;
    logic [1:0]          done_o;
    logic [1:0]          busy_o;

    always #5 clk = ~clk;

    synch_up_counter #(.WIDTH(W), .ONE_SHOT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .d(d), .load(load), .en(en), .limit(limit),
        .q(q_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .ovf(ovf_o[0]),
        .done(done_o[0]), .busy(busy_o[0])
    );

    synch_up_counter #(.WIDTH(W), .ONE_SHOT(1'b1)) dut_shot (
        .clk(clk), .rst(rst), .d(d), .load(load), .en(en), .limit(limit),
        .q(q_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .ovf(ovf_o[1]),
        .done(done_o[1]), .busy(busy_o[1])
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        int q;
        bit running;
        bit stopped;
        bit ovf;
        bit wrap;
    } model_t;

    model_t m [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].q       = 0;
            m[i].running = 1'b0;
            m[i].stopped = 1'b0;
            m[i].ovf     = 1'b0;
            m[i].wrap    = 1'b0;
        end
    endfunction

    // One clock edge of the counter, for the wrapping (i=0) or one-shot (i=1)
    // flavour, from the inputs present at that edge.
    function automatic void model_step(input int i, input bit ld, input bit cnt,
                                       input int dv, input int lim);
        m[i].wrap = 1'b0;
        if (ld) begin
            m[i].q       = dv;
            m[i].running = 1'b0;
            m[i].stopped = 1'b0;
            m[i].ovf     = 1'b0;
        end else if (m[i].stopped) begin
            // parked until a load
        end else if (!cnt) begin
            m[i].running = 1'b0;
        end else if (m[i].q >= lim) begin
            if (i == 1) begin
                m[i].stopped = 1'b1;
                m[i].running = 1'b0;
            end else begin
                m[i].q       = 0;
                m[i].wrap    = 1'b1;
                m[i].ovf     = 1'b1;
                m[i].running = 1'b1;
            end
        end else begin
            m[i].q       = m[i].q + 1;
            m[i].running = 1'b1;
        end
    endfunction

    task automatic verify(input string ph);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.q%0d", ph, i),    int'(q_o[i]),    m[i].q);
            check($sformatf("%s.tc%0d", ph, i),   int'(tc_o[i]),   int'(m[i].q >= int'(limit)));
            check($sformatf("%s.wrap%0d", ph, i), int'(wrap_o[i]), int'(m[i].wrap));
            check($sformatf("%s.ovf%0d", ph, i),  int'(ovf_o[i]),  int'(m[i].ovf));
            check($sformatf("%s.done%0d", ph, i), int'(done_o[i]), int'(m[i].stopped));
            check($sformatf("%s.busy%0d", ph, i), int'(busy_o[i]), int'(m[i].running));
        end
    endtask

    // Advance one edge: update the model from the inputs at the edge, then
    // sample the DUTs 1 time unit later.
    task automatic tick(input string ph);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, load, en, int'(d), int'(limit));
        #1;
        verify(ph);
    endtask

    task automatic do_load(input int dv, input bit with_en, input string ph);
        d    = W'(dv);
        load = 1'b1;
        en   = with_en;
        tick(ph);
        load = 1'b0;
    endtask

    // Assert reset between edges, verify the immediate clear, release before
    // the next edge.
    task automatic do_reset(input string ph);
        rst = 1'b0;
        #1;
        model_reset();
        verify(ph);
        #1;
        rst = 1'b1;
    endtask

    int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        model_reset();
        #3;
        verify("reset");
        rst = 1'b1;

        // 1: load 1, count to 15 in 14 edges, then wrap with sticky ovf.
        limit = 4'hF;
        do_load(1, 1'b1, "t1_load");
        check("t1_load_no_inc", int'(q_o[0]), 1);
        en = 1'b1;
        for (int k = 0; k < 14; k++) tick("t1_cnt");
        check("t1_q15", int'(q_o[0]), 15);
        check("t1_tc", int'(tc_o[0]), 1);
        tick("t1_wrap");
        check("t1_q0", int'(q_o[0]), 0);
        check("t1_wrap_pulse", int'(wrap_o[0]), 1);
        tick("t1_after");
        check("t1_wrap_gone", int'(wrap_o[0]), 0);
        check("t1_ovf_sticky", int'(ovf_o[0]), 1);

        // 2: limit 5 from 0, seven edges.
        limit = 4'h5;
        do_load(0, 1'b0, "t2_load");
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick("t2_cnt");
            check($sformatf("t2_seq%0d", k), int'(q_o[0]), exp_seq[k]);
            check($sformatf("t2_wrap%0d", k), int'(wrap_o[0]), int'(k == 5));
        end

        // 3: climb to 7 with ovf set, then load 3 with en on the same edge.
        limit = 4'hF;
        for (int k = 0; k < 6; k++) tick("t3_climb");
        check("t3_q7", int'(q_o[0]), 7);
        check("t3_ovf_pre", int'(ovf_o[0]), 1);
        do_load(3, 1'b1, "t3_load");
        check("t3_q3", int'(q_o[0]), 3);
        check("t3_ovf_clr", int'(ovf_o[0]), 0);

        // 4: one-shot stop at limit 3, en toggling ignored, load releases.
        limit = 4'h3;
        do_load(0, 1'b0, "t4_load");
        en = 1'b1;
        for (int k = 0; k < 5; k++) tick("t4_cnt");
        check("t4_q3", int'(q_o[1]), 3);
        check("t4_done", int'(done_o[1]), 1);
        check("t4_busy", int'(busy_o[1]), 0);
        en = 1'b0; tick("t4_en0");
        en = 1'b1; tick("t4_en1");
        check("t4_held", int'(q_o[1]), 3);
        do_load(0, 1'b0, "t4_reload");
        check("t4_done_clr", int'(done_o[1]), 0);

        // 5: d above limit is terminal immediately.
        limit = 4'h5;
        do_load(10, 1'b0, "t5_load");
        check("t5_tc", int'(tc_o[0]), 1);
        en = 1'b1;
        tick("t5_edge");
        check("t5_q0", int'(q_o[0]), 0);
        check("t5_wrap", int'(wrap_o[0]), 1);

        // limit = 0: every counting edge is terminal.
        limit = 4'h0;
        do_load(0, 1'b0, "lim0_load");
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick("lim0");
            check($sformatf("lim0_wrap%0d", k), int'(wrap_o[0]), 1);
        end

        // 6: asynchronous reset mid-count, resume from 1.
        limit = 4'hF;
        do_load(6, 1'b0, "t6_load");
        en = 1'b1;
        do_reset("t6_rst");
        check("t6_q0", int'(q_o[0]), 0);
        tick("t6_resume");
        check("t6_q1", int'(q_o[0]), 1);

        // Randomized traffic, including limit changes and occasional resets.
        for (int k = 0; k < 400; k++) begin
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            d    = W'($urandom_range(0, MAXV));
            if ($urandom_range(0, 15) == 0) limit = W'($urandom_range(0, MAXV));
            if ($urandom_range(0, 63) == 0) do_reset("rnd_rst");
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
